tcp_tx_chksum_realign_ctrl: RTL and testbench
=============================================

// Module: tcp_tx_chksum_realign_ctrl
// PURPOSE
//  Parametrised TX checksum front-end. Strips the pseudo header from the top of each packet's first beat.
//  Pushes {src_ip, dst_ip, tcp_len, timestamp} into a header queue; payload-side holds at most one packet.
//  Re-aligns the payload MSB-first onto the MAC-width stream, with per-beat padbytes.
//  Unlike the lock-step predecessor, header and payload channels are decoupled by the queue.
//  Handles zero-length, over-long and short packets.
// PARAMETERS
//  DATA_W          256  input/output data width, bits (multiple of 8)
//  PHDR_BYTES      12   pseudo-header bytes at top of beat 0 (S); 0 < S < DATA_W/8
//  HDR_FIFO_DEPTH  4    header queue entries (power of 2, >=2)
//  USER_W          `PKT_TIMESTAMP_W  tuser/timestamp width
//  LEN_W           `TOT_LEN_W        TCP length width
// PORTS
//  clk                          in   1          clock
//  rst                          in   1          synchronous, active-high reset
//  resp_tdata/tkeep/tuser       in   DATA_W/DATA_W/8/USER_W   input beat; tkeep ignored
//  resp_tval/tlast              in   1          input valid / last beat
//  resp_trdy                    out  1          input ready
//  chksum_dst_tx_hdr_val        out  1          header queue non-empty
//  dst_chksum_tx_hdr_rdy        in   1          header pop
//  chksum_dst_tx_src_ip/dst_ip  out  `IP_ADDR_W each   queue head fields
//  chksum_dst_tx_tcp_len        out  LEN_W      queue head pseudo-header length
//  chksum_dst_tx_timestamp      out  USER_W     tuser of beat 0
//  chksum_dst_tx_data_val/last  out  1          payload valid / last
//  dst_chksum_tx_data_rdy       in   1          payload ready
//  chksum_dst_tx_data           out  DATA_W     payload, bytes past padbytes zeroed on last
//  chksum_dst_tx_data_padbytes  out  $clog2(DATA_W/8)+1   invalid low bytes; 0 unless last
//  chksum_dst_tx_data_err       out  1          valid only with last: packet shorter than tcp_len
// BEHAVIOUR
//  Reset: FSM->IDLE, queue empty, hold/bytes_left=0; all val/last/err/padbytes outputs=0.
//  Reset mid-packet discards the partial packet; no recovery beats are emitted.
//  Wb=DATA_W/8. hold = low Wb-S bytes of the last accepted beat.
//  Output beat = {hold, top S bytes of the current input beat}.
//  IDLE: trdy=!hdr_full; no full-queue bypass, even with a simultaneous pop.
//   On accept: push header (tcp_len = pseudo-header length, timestamp = tuser); load hold; bytes_left=L.
//   Next state: L==0 -> IDLE if tlast else DRAIN; tlast -> FLUSH; else STREAM.
//  STREAM: data_val=tval, trdy=data_rdy (combinational; output latency 0 from beat k+1).
//   On a handshake, hold reloads and one of:
//   bytes_left<=Wb -> last=1, pad=Wb-bytes_left; next IDLE if tlast, else DRAIN.
//   else if tlast  -> bytes_left-=Wb; next FLUSH.
//   else           -> bytes_left-=Wb; stay in STREAM.
//  FLUSH: trdy=0, data_val=1, last=1, data={hold,0}.
//   pad = Wb-min(bytes_left,Wb-S); err = bytes_left>Wb-S. On data_rdy -> IDLE.
//  DRAIN: trdy=1, no output; accept and drop beats until tlast -> IDLE. Excess bytes are discarded silently.
//  Header queue: hdr_val=!empty. Push and pop in the same cycle are both honoured.
//   The header for packet N+1 may be pushed before header N is popped.
//  bytes_left is LEN_W wide unsigned; decrements never underflow because of the <=Wb guard.
//  Outputs hold steady while val && !rdy.
// STRUCTURE
//  packet_struct_pkg: chksum_pseudo_hdr struct, CHKSUM_PSEUDO_HDR_BYTES, realign state enum, tx_hdr_entry struct.
//  Sub-module tcp_chksum_hdr_fifo (DEPTH x tx_hdr_entry, sync, full/empty); data_masker for the tail zeroing.
// TESTING (DATA_W=256, S=12, Wb=32)
//  L=40, 2 in-beats -> 2 out beats; 2nd last pad=24 err=0; hdr tcp_len=40.
//  L=20, 1 in-beat tlast -> FLUSH beat pad=12 = beat0 low 20B then zeros.
//  L=32, 2 in-beats -> exactly 1 out beat last pad=0; no FLUSH cycle.
//  L=0, 1 beat -> header only, zero data beats; next packet accepted next cycle.
//  5 pkts L=20, hdr_rdy=0 -> 4 headers queued; trdy=0 on 5th beat0 until first pop.
//  L=60 short, 2 beats -> last pad=12 err=1.
//  L=8 over-long, 3 beats -> 1 out beat pad=24 err=0; 3rd beat dropped in DRAIN.

Source files
------------

// File: rtl/packet_struct_pkg.sv
// Shared packet types for the TCP TX checksum path.
//  - chksum_pseudo_hdr : TCP/IPv4 pseudo header as it sits MSB-first at the top of beat 0
//  - tx_hdr_entry      : one header-queue entry handed to the checksum engine
//  - ST_* constants    : realign FSM state encoding
package packet_struct_pkg;

    localparam int IP_ADDR_W               = 32;
    localparam int TOT_LEN_W               = 16;
    localparam int PKT_TIMESTAMP_W         = 64;
    localparam int CHKSUM_PSEUDO_HDR_BYTES = 12;

    typedef struct packed {
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
        logic [7:0]           zeros;
        logic [7:0]           protocol;
        logic [15:0]          tcp_len;
    } chksum_pseudo_hdr;

    typedef struct packed {
        logic [IP_ADDR_W-1:0]       src_ip;
        logic [IP_ADDR_W-1:0]       dst_ip;
        logic [TOT_LEN_W-1:0]       tcp_len;
        logic [PKT_TIMESTAMP_W-1:0] timestamp;
    } tx_hdr_entry;

    // Realign FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;  // waiting for beat 0 of a packet
    localparam logic [1:0] ST_STREAM = 2'd1;  // re-aligning payload beats
    localparam logic [1:0] ST_FLUSH  = 2'd2;  // emitting the held tail after tlast
    localparam logic [1:0] ST_DRAIN  = 2'd3;  // dropping input past tcp_len

endpackage

// File: rtl/data_masker.sv
// Zeroes the low `padbytes` bytes of a beat (byte 0 = least significant byte).
// Ports: data_in, padbytes -> data_out. Purely combinational.
module data_masker #(
    parameter int DATA_W = 256,
    parameter int PAD_W  = 6
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAD_W-1:0]  padbytes,
    output logic [DATA_W-1:0] data_out
);

    localparam int WB = DATA_W / 8;

    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_byte
            assign data_out[gi*8 +: 8] = (PAD_W'(gi) < padbytes) ? 8'h00 : data_in[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/tcp_chksum_hdr_fifo.sv
// Small synchronous header queue (DEPTH x tx_hdr_entry), show-ahead head output.
// Ports: clk/rst, push + push_entry, pop, head (valid while !empty), full, empty.
// A push and a pop in the same cycle are both honoured.
module tcp_chksum_hdr_fifo
    import packet_struct_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  tx_hdr_entry push_entry,
    input  logic        pop,
    output tx_hdr_entry head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    tx_hdr_entry    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tcp_tx_chksum_realign_ctrl.sv
// TX checksum front-end. Strips the pseudo header from the top of beat 0, queues
// {src_ip, dst_ip, tcp_len, timestamp}, and re-aligns the payload MSB-first onto the
// output stream with per-beat padbytes on the last beat.
// Ports: resp_* input stream (tkeep ignored); chksum_dst_tx_hdr_* header queue head with
// dst_chksum_tx_hdr_rdy pop; chksum_dst_tx_data_* payload stream with dst_chksum_tx_data_rdy.
module tcp_tx_chksum_realign_ctrl
    import packet_struct_pkg::*;
#(
    parameter int DATA_W         = 256,
    parameter int PHDR_BYTES     = 12,
    parameter int HDR_FIFO_DEPTH = 4,
    parameter int USER_W         = PKT_TIMESTAMP_W,
    parameter int LEN_W          = TOT_LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            resp_tdata,
    input  logic [DATA_W/8-1:0]          resp_tkeep,
    input  logic [USER_W-1:0]            resp_tuser,
    input  logic                         resp_tval,
    input  logic                         resp_tlast,
    output logic                         resp_trdy,
    output logic                         chksum_dst_tx_hdr_val,
    input  logic                         dst_chksum_tx_hdr_rdy,
    output logic [IP_ADDR_W-1:0]         chksum_dst_tx_src_ip,
    output logic [IP_ADDR_W-1:0]         chksum_dst_tx_dst_ip,
    output logic [LEN_W-1:0]             chksum_dst_tx_tcp_len,
    output logic [USER_W-1:0]            chksum_dst_tx_timestamp,
    output logic                         chksum_dst_tx_data_val,
    output logic                         chksum_dst_tx_data_last,
    input  logic                         dst_chksum_tx_data_rdy,
    output logic [DATA_W-1:0]            chksum_dst_tx_data,
    output logic [$clog2(DATA_W/8):0]    chksum_dst_tx_data_padbytes,
    output logic                         chksum_dst_tx_data_err
);

    localparam int WB     = DATA_W / 8;
    localparam int S      = PHDR_BYTES;
    localparam int HOLD_W = (WB - S) * 8;
    localparam int TOP_W  = S * 8;
    localparam int PAD_W  = $clog2(WB) + 1;
    localparam int PHDR_W = CHKSUM_PSEUDO_HDR_BYTES * 8;
    localparam logic [LEN_W-1:0] WB_LEN   = LEN_W'(WB);
    localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(WB - S);

    logic [1:0]        state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [LEN_W-1:0]  bytes_left_reg, bytes_left_next;

    chksum_pseudo_hdr  phdr;
    logic [LEN_W-1:0]  pkt_len;
    tx_hdr_entry       push_entry;
    tx_hdr_entry       hdr_head;
    logic              hdr_push;
    logic              hdr_full;
    logic              hdr_empty;
    logic [DATA_W-1:0] raw_data;
    logic              unused_bits;

    assign phdr        = resp_tdata[DATA_W-1 -: PHDR_W];
    assign pkt_len     = LEN_W'(phdr.tcp_len);
    assign unused_bits = ^{resp_tkeep, phdr.zeros, phdr.protocol};

    always_comb begin
        push_entry.src_ip    = phdr.src_ip;
        push_entry.dst_ip    = phdr.dst_ip;
        push_entry.tcp_len   = phdr.tcp_len;
        push_entry.timestamp = PKT_TIMESTAMP_W'(resp_tuser);
    end

    tcp_chksum_hdr_fifo #(
        .DEPTH (HDR_FIFO_DEPTH)
    ) u_hdr_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (hdr_push),
        .push_entry (push_entry),
        .pop        (dst_chksum_tx_hdr_rdy),
        .head       (hdr_head),
        .full       (hdr_full),
        .empty      (hdr_empty)
    );

    assign chksum_dst_tx_hdr_val   = !hdr_empty;
    assign chksum_dst_tx_src_ip    = hdr_head.src_ip;
    assign chksum_dst_tx_dst_ip    = hdr_head.dst_ip;
    assign chksum_dst_tx_tcp_len   = LEN_W'(hdr_head.tcp_len);
    assign chksum_dst_tx_timestamp = USER_W'(hdr_head.timestamp);

    always_comb begin
        state_next                  = state_reg;
        hold_next                   = hold_reg;
        bytes_left_next             = bytes_left_reg;
        resp_trdy                   = 1'b0;
        hdr_push                    = 1'b0;
        chksum_dst_tx_data_val      = 1'b0;
        chksum_dst_tx_data_last     = 1'b0;
        chksum_dst_tx_data_err      = 1'b0;
        chksum_dst_tx_data_padbytes = '0;
        raw_data                    = '0;

        case (state_reg)
            ST_IDLE: begin
                // No bypass when full: a same-cycle pop does not open the gate.
                resp_trdy = !hdr_full;
                if (resp_tval && !hdr_full) begin
                    hdr_push        = 1'b1;
                    hold_next       = resp_tdata[HOLD_W-1:0];
                    bytes_left_next = pkt_len;
                    if (pkt_len == '0)   state_next = resp_tlast ? ST_IDLE : ST_DRAIN;
                    else if (resp_tlast) state_next = ST_FLUSH;
                    else                 state_next = ST_STREAM;
                end
            end

            ST_STREAM: begin
                // Output is formed combinationally from the held tail and the current beat.
                resp_trdy              = dst_chksum_tx_data_rdy;
                chksum_dst_tx_data_val = resp_tval;
                raw_data               = {hold_reg, resp_tdata[DATA_W-1 -: TOP_W]};
                if (resp_tval && bytes_left_reg <= WB_LEN) begin
                    chksum_dst_tx_data_last     = 1'b1;
                    chksum_dst_tx_data_padbytes = PAD_W'(WB_LEN - bytes_left_reg);
                end
                if (resp_tval && dst_chksum_tx_data_rdy) begin
                    hold_next = resp_tdata[HOLD_W-1:0];
                    if (bytes_left_reg <= WB_LEN) begin
                        bytes_left_next = '0;
                        state_next      = resp_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        bytes_left_next = bytes_left_reg - WB_LEN;
                        state_next      = resp_tlast ? ST_FLUSH : ST_STREAM;
                    end
                end
            end

            ST_FLUSH: begin
                // Only the held tail remains; more owed bytes than held means a short packet.
                chksum_dst_tx_data_val  = 1'b1;
                chksum_dst_tx_data_last = 1'b1;
                raw_data                = {hold_reg, {TOP_W{1'b0}}};
                if (bytes_left_reg > TAIL_LEN) begin
                    chksum_dst_tx_data_err      = 1'b1;
                    chksum_dst_tx_data_padbytes = PAD_W'(S);
                end else begin
                    chksum_dst_tx_data_padbytes = PAD_W'(WB_LEN - bytes_left_reg);
                end
                if (dst_chksum_tx_data_rdy) begin
                    bytes_left_next = '0;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                resp_trdy = 1'b1;
                if (resp_tval && resp_tlast) state_next = ST_IDLE;
            end
        endcase
    end

    data_masker #(
        .DATA_W (DATA_W),
        .PAD_W  (PAD_W)
    ) u_masker (
        .data_in  (raw_data),
        .padbytes (chksum_dst_tx_data_padbytes),
        .data_out (chksum_dst_tx_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            bytes_left_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            bytes_left_reg <= bytes_left_next;
        end
    end

endmodule

// File: tb/tb_tcp_tx_chksum_realign_ctrl.sv
// Directed bench for tcp_tx_chksum_realign_ctrl (DATA_W=256, S=12, Wb=32).
// Packets are built from a byte generator pb(p,i); the expected output stream is the
// first min(L, supplied) payload bytes packed MSB-first into 32-byte beats, zero-filled.
module tb_tcp_tx_chksum_realign_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] resp_tdata;
    logic [31:0]  resp_tkeep;
    logic [63:0]  resp_tuser;
    logic         resp_tval, resp_tlast, resp_trdy;
    logic         hdr_val, hdr_rdy;
    logic [31:0]  src_ip, dst_ip;
    logic [15:0]  tcp_len;
    logic [63:0]  ts;
    logic         data_val, data_last, data_rdy, data_err;
    logic [255:0] data;
    logic [5:0]   pad;

    int total = 0;
    int bad   = 0;

    logic [255:0] out_d_q[$];
    logic [5:0]   out_p_q[$];
    logic         out_l_q[$];
    logic         out_e_q[$];
    logic [31:0]  hdr_src_q[$];
    logic [31:0]  hdr_dst_q[$];
    logic [15:0]  hdr_len_q[$];
    logic [63:0]  hdr_ts_q[$];

    always #5 clk = ~clk;

    tcp_tx_chksum_realign_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .resp_tdata                  (resp_tdata),
        .resp_tkeep                  (resp_tkeep),
        .resp_tuser                  (resp_tuser),
        .resp_tval                   (resp_tval),
        .resp_tlast                  (resp_tlast),
        .resp_trdy                   (resp_trdy),
        .chksum_dst_tx_hdr_val       (hdr_val),
        .dst_chksum_tx_hdr_rdy       (hdr_rdy),
        .chksum_dst_tx_src_ip        (src_ip),
        .chksum_dst_tx_dst_ip        (dst_ip),
        .chksum_dst_tx_tcp_len       (tcp_len),
        .chksum_dst_tx_timestamp     (ts),
        .chksum_dst_tx_data_val      (data_val),
        .chksum_dst_tx_data_last     (data_last),
        .dst_chksum_tx_data_rdy      (data_rdy),
        .chksum_dst_tx_data          (data),
        .chksum_dst_tx_data_padbytes (pad),
        .chksum_dst_tx_data_err      (data_err)
    );

    // Capture handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (data_val && data_rdy) begin
                out_d_q.push_back(data);
                out_p_q.push_back(pad);
                out_l_q.push_back(data_last);
                out_e_q.push_back(data_err);
            end
            if (hdr_val && hdr_rdy) begin
                hdr_src_q.push_back(src_ip);
                hdr_dst_q.push_back(dst_ip);
                hdr_len_q.push_back(tcp_len);
                hdr_ts_q.push_back(ts);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pb(input int p, input int i);
        return 8'((p * 37 + i + 1) & 255);
    endfunction

    function automatic logic [255:0] make_beat(input int p, input int b, input int len);
        logic [255:0] v;
        v = '0;
        if (b == 0) begin
            v[255:224] = 32'hC0A8_0000 + 32'(p);
            v[223:192] = 32'h0A00_0000 + 32'(p);
            v[191:184] = 8'h00;
            v[183:176] = 8'h06;
            v[175:160] = 16'(len);
            for (int j = 0; j < 20; j++) v[159-8*j -: 8] = pb(p, j);
        end else begin
            for (int j = 0; j < 32; j++) v[255-8*j -: 8] = pb(p, 20 + 32*(b-1) + j);
        end
        return v;
    endfunction

    function automatic logic [255:0] exp_beat(input int p, input int n, input int valid);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 32; j++) begin
            if (32*n + j < valid) v[255-8*j -: 8] = pb(p, 32*n + j);
        end
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and wait (bounded) for the handshake; returns cycles taken.
    task automatic send_beat(input logic [255:0] d, input logic last, input logic [63:0] user,
                             output int cycles);
        logic acc;
        acc        = 1'b0;
        cycles     = 0;
        resp_tdata = d;
        resp_tlast = last;
        resp_tuser = user;
        resp_tval  = 1'b1;
        while (!acc && cycles < 200) begin
            @(negedge clk);
            acc = resp_trdy;
            @(posedge clk);
            #1;
            cycles++;
        end
        resp_tval  = 1'b0;
        resp_tlast = 1'b0;
        chk("beat_accept", 32'(acc), 32'd1);
    endtask

    task automatic check_out(input int p, input int len, input int supplied,
                             input int exp_nout, input int exp_pad, input int exp_err);
        int   valid;
        logic is_last;
        valid = (len < supplied) ? len : supplied;
        chk("out_beats", 32'(out_d_q.size()), 32'(exp_nout));
        for (int n = 0; n < exp_nout && out_d_q.size() > 0; n++) begin
            is_last = (n == exp_nout - 1);
            chk_w("out_data", out_d_q.pop_front(), exp_beat(p, n, valid));
            chk("out_last", 32'(out_l_q.pop_front()), 32'(is_last));
            chk("out_pad", 32'(out_p_q.pop_front()), is_last ? 32'(exp_pad) : 32'd0);
            chk("out_err", 32'(out_e_q.pop_front()), is_last ? 32'(exp_err) : 32'd0);
        end
        out_d_q.delete();
        out_p_q.delete();
        out_l_q.delete();
        out_e_q.delete();
    endtask

    task automatic check_hdr(input int p, input int len);
        chk("hdr_avail", 32'(hdr_len_q.size() > 0), 32'd1);
        if (hdr_len_q.size() > 0) begin
            chk("hdr_src", hdr_src_q.pop_front(), 32'hC0A8_0000 + 32'(p));
            chk("hdr_dst", hdr_dst_q.pop_front(), 32'h0A00_0000 + 32'(p));
            chk("hdr_len", 32'(hdr_len_q.pop_front()), 32'(len));
            chk_w("hdr_ts", 256'(hdr_ts_q.pop_front()), 256'(64'h1000 + 64'(p)));
        end
    endtask

    task automatic run_pkt(input int p, input int len, input int nbeats,
                           input int exp_nout, input int exp_pad, input int exp_err);
        int cyc;
        for (int b = 0; b < nbeats; b++) begin
            send_beat(make_beat(p, b, len), (b == nbeats - 1),
                      (b == 0) ? 64'h1000 + 64'(p) : 64'hBAD0 + 64'(b), cyc);
        end
        idle(4);
        check_out(p, len, 20 + 32*(nbeats-1), exp_nout, exp_pad, exp_err);
        check_hdr(p, len);
    endtask

    initial begin
        int cyc;
        rst        = 1'b1;
        resp_tdata = '0;
        resp_tkeep = '1;
        resp_tuser = '0;
        resp_tval  = 1'b0;
        resp_tlast = 1'b0;
        hdr_rdy    = 1'b1;
        data_rdy   = 1'b1;
        idle(3);

        // Reset state
        chk("rst_data_val", 32'(data_val), 32'd0);
        chk("rst_data_last", 32'(data_last), 32'd0);
        chk("rst_data_err", 32'(data_err), 32'd0);
        chk("rst_pad", 32'(pad), 32'd0);
        chk("rst_hdr_val", 32'(hdr_val), 32'd0);
        rst = 1'b0;
        idle(1);
        chk("idle_trdy", 32'(resp_trdy), 32'd1);

        // L=40 two beats; L=32 exact fit; L=60 short; L=8 over-long
        run_pkt(1, 40, 2, 2, 24, 0);
        run_pkt(2, 32, 2, 1, 0, 0);
        run_pkt(3, 60, 2, 2, 12, 1);
        run_pkt(4, 8, 3, 1, 24, 0);

        // L=20 single beat, FLUSH beat held under back-pressure
        data_rdy = 1'b0;
        send_beat(make_beat(5, 0, 20), 1'b1, 64'h1005, cyc);
        #1;
        chk("flush_val", 32'(data_val), 32'd1);
        chk("flush_last", 32'(data_last), 32'd1);
        chk("flush_pad", 32'(pad), 32'd12);
        chk("flush_trdy", 32'(resp_trdy), 32'd0);
        idle(2);
        chk("flush_hold_val", 32'(data_val), 32'd1);
        chk_w("flush_hold_data", data, exp_beat(5, 0, 20));
        data_rdy = 1'b1;
        idle(3);
        check_out(5, 20, 20, 1, 12, 0);
        check_hdr(5, 20);

        // L=0 header only, next packet accepted on the very next cycle
        send_beat(make_beat(6, 0, 0), 1'b1, 64'h1006, cyc);
        send_beat(make_beat(7, 0, 20), 1'b1, 64'h1007, cyc);
        chk("l0_next_cycles", 32'(cyc), 32'd1);
        idle(4);
        check_out(7, 20, 20, 1, 12, 0);
        check_hdr(6, 0);
        check_hdr(7, 20);

        // Header queue fills at 4 entries; 5th beat 0 stalls until a pop
        hdr_rdy = 1'b0;
        for (int p = 10; p < 14; p++) begin
            send_beat(make_beat(p, 0, 20), 1'b1, 64'h1000 + 64'(p), cyc);
            idle(3);
            check_out(p, 20, 20, 1, 12, 0);
        end
        resp_tdata = make_beat(14, 0, 20);
        resp_tlast = 1'b1;
        resp_tuser = 64'h100E;
        resp_tval  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_trdy", 32'(resp_trdy), 32'd0);
        end
        @(posedge clk);
        #1;
        hdr_rdy = 1'b1;
        @(negedge clk);
        chk("full_pop_trdy", 32'(resp_trdy), 32'd0);
        chk("full_hdr_val", 32'(hdr_val), 32'd1);
        @(posedge clk);
        #1;
        hdr_rdy = 1'b0;
        send_beat(make_beat(14, 0, 20), 1'b1, 64'h100E, cyc);
        chk("after_pop_cycles", 32'(cyc), 32'd1);
        idle(3);
        check_out(14, 20, 20, 1, 12, 0);
        hdr_rdy = 1'b1;
        idle(6);
        for (int p = 10; p < 15; p++) check_hdr(p, 20);

        // Reset mid-packet discards the partial packet and its header
        hdr_rdy = 1'b0;
        send_beat(make_beat(20, 0, 40), 1'b0, 64'h1014, cyc);
        rst = 1'b1;
        idle(1);
        rst      = 1'b0;
        data_rdy = 1'b0;
        idle(1);
        chk("midrst_hdr_val", 32'(hdr_val), 32'd0);
        chk("midrst_trdy", 32'(resp_trdy), 32'd1);
        chk("midrst_data_val", 32'(data_val), 32'd0);
        data_rdy = 1'b1;
        hdr_rdy  = 1'b1;
        out_d_q.delete();
        out_p_q.delete();
        out_l_q.delete();
        out_e_q.delete();
        run_pkt(21, 20, 1, 1, 12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
